// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM controller: FSM states, ALU command
// and control codes, condition codes, mux select values and the condition evaluator.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9
  } state_e;

  localparam logic [1:0] OpDp  = 2'b00;
  localparam logic [1:0] OpMem = 2'b01;
  localparam logic [1:0] OpBr  = 2'b10;
  localparam logic [1:0] OpIll = 2'b11;

  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdEor = 4'b0001;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdCmp = 4'b1010;
  localparam logic [3:0] CmdOrr = 4'b1100;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOrr = 3'b011;
  localparam logic [2:0] AluEor = 3'b100;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;
  localparam logic [3:0] CondNv = 4'b1111;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  // nzcv is {N, Z, C, V}
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    unique case (cond)
      CondEq: cond_holds = z;
      CondNe: cond_holds = ~z;
      CondCs: cond_holds = c;
      CondCc: cond_holds = ~c;
      CondMi: cond_holds = n;
      CondPl: cond_holds = ~n;
      CondVs: cond_holds = v;
      CondVc: cond_holds = ~v;
      CondHi: cond_holds = c & ~z;
      CondLs: cond_holds = ~c | z;
      CondGe: cond_holds = (n == v);
      CondLt: cond_holds = (n != v);
      CondGt: cond_holds = ~z & (n == v);
      CondLe: cond_holds = z | (n != v);
      CondAl: cond_holds = 1'b1;
      CondNv: cond_holds = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_mc_main_fsm.sv
// Main sequencer of the multicycle controller: Moore FSM producing raw (ungated) per-state
// write strobes and datapath mux selects.
module arm_mc_main_fsm
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_op,
  input  logic       i_funct_i,
  input  logic       i_funct_l,
  input  logic [3:0] i_cmd,
  output logic [3:0] o_state,
  output logic       o_reg_w,
  output logic       o_mem_w,
  output logic       o_branch,
  output logic       o_ir_write,
  output logic       o_next_pc,
  output logic       o_adr_src,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic       o_alu_op,
  output logic       o_illegal
);

  state_e r_state;
  state_e w_state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign o_state = r_state;

  always_comb begin
    w_state_next = StFetch;
    o_reg_w      = 1'b0;
    o_mem_w      = 1'b0;
    o_branch     = 1'b0;
    o_ir_write   = 1'b0;
    o_next_pc    = 1'b0;
    o_adr_src    = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = SrcBReg;
    o_result_src = ResAluOut;
    o_alu_op     = 1'b0;
    o_illegal    = 1'b0;
    case (r_state)
      StFetch: begin
        w_state_next = StDecode;
        o_ir_write   = 1'b1;
        o_next_pc    = 1'b1;
        o_alu_src_a  = 1'b1;
        o_alu_src_b  = SrcBFour;
        o_result_src = ResAluResult;
      end
      StDecode: begin
        o_alu_src_a  = 1'b1;
        o_alu_src_b  = SrcBFour;
        o_result_src = ResAluResult;
        unique case (i_op)
          OpMem: w_state_next = StMemAdr;
          OpDp:  w_state_next = i_funct_i ? StExecuteI : StExecuteR;
          OpBr:  w_state_next = StBranch;
          OpIll: begin
            w_state_next = StFetch;
            o_illegal    = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        o_alu_src_b  = SrcBImm;
        w_state_next = i_funct_l ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        o_adr_src    = 1'b1;
        w_state_next = StMemWb;
      end
      StMemWb: begin
        o_result_src = ResData;
        o_reg_w      = 1'b1;
      end
      StMemWrite: begin
        o_adr_src = 1'b1;
        o_mem_w   = 1'b1;
      end
      StExecuteR, StExecuteI: begin
        o_alu_src_b  = (r_state == StExecuteI) ? SrcBImm : SrcBReg;
        o_alu_op     = 1'b1;
        // CMP has no register result, so it skips writeback
        w_state_next = (i_cmd == CmdCmp) ? StFetch : StAluWb;
      end
      StAluWb: begin
        o_reg_w = 1'b1;
      end
      StBranch: begin
        o_alu_src_b  = SrcBImm;
        o_result_src = ResAluResult;
        o_branch     = 1'b1;
      end
      default: w_state_next = StFetch;
    endcase
  end

endmodule

// File: rtl/arm_mc_control_unit.sv
// Multicycle ARM control unit: wraps the main FSM with the ALU decoder, the NZCV register,
// condition evaluation against the registered flags, and write gating.
module arm_mc_control_unit
  import arm_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W   = 2,
  parameter logic [3:0]  FLAGS_RESET = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           Cond,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           Flags,
  output logic                 illegal,
  output logic [3:0]           state
);

  localparam logic [ALUCTRL_W-1:0] AluEorCode =
    (ALUCTRL_W >= 3) ? ALUCTRL_W'(AluEor) : ALUCTRL_W'(AluAdd);

  logic       w_reg_w, w_mem_w, w_branch, w_ir_write, w_next_pc, w_alu_op, w_illegal;
  logic       w_cond_ex, w_flag_upd, w_cv_upd;
  logic [3:0] w_cmd;
  logic [3:0] r_flags;
  logic [ALUCTRL_W-1:0] w_alu_ctrl;

  assign w_cmd = Funct[4:1];

  arm_mc_main_fsm u_main_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_op         (Op),
    .i_funct_i    (Funct[5]),
    .i_funct_l    (Funct[0]),
    .i_cmd        (w_cmd),
    .o_state      (state),
    .o_reg_w      (w_reg_w),
    .o_mem_w      (w_mem_w),
    .o_branch     (w_branch),
    .o_ir_write   (w_ir_write),
    .o_next_pc    (w_next_pc),
    .o_adr_src    (AdrSrc),
    .o_alu_src_a  (ALUSrcA),
    .o_alu_src_b  (ALUSrcB),
    .o_result_src (ResultSrc),
    .o_alu_op     (w_alu_op),
    .o_illegal    (w_illegal)
  );

  always_comb begin
    w_alu_ctrl = ALUCTRL_W'(AluAdd);
    if (w_alu_op) begin
      case (w_cmd)
        CmdAdd:         w_alu_ctrl = ALUCTRL_W'(AluAdd);
        CmdSub, CmdCmp: w_alu_ctrl = ALUCTRL_W'(AluSub);
        CmdAnd:         w_alu_ctrl = ALUCTRL_W'(AluAnd);
        CmdOrr:         w_alu_ctrl = ALUCTRL_W'(AluOrr);
        CmdEor:         w_alu_ctrl = AluEorCode;
        default:        w_alu_ctrl = ALUCTRL_W'(AluAdd);
      endcase
    end
  end

  assign ALUControl = w_alu_ctrl;

  // Condition uses registered flags, so an update in this execute cycle is not yet visible
  assign w_cond_ex  = cond_holds(Cond, r_flags);
  assign w_flag_upd = w_alu_op & Funct[0] & w_cond_ex;
  assign w_cv_upd   = (w_cmd == CmdAdd) | (w_cmd == CmdSub) | (w_cmd == CmdCmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= FLAGS_RESET;
    end else if (w_flag_upd) begin
      r_flags[3:2] <= ALUFlags[3:2];
      if (w_cv_upd) begin
        r_flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  assign Flags  = r_flags;
  assign ImmSrc = Op;
  assign RegSrc = {Op == OpMem, Op == OpBr};

  // Strobes are held low for the whole reset, even though the FSM already sits in FETCH
  assign IRWrite  = rst_n & w_ir_write;
  assign RegWrite = rst_n & w_reg_w & w_cond_ex;
  assign MemWrite = rst_n & w_mem_w & w_cond_ex;
  assign PCWrite  = rst_n & (w_next_pc | (w_cond_ex & (w_branch | (w_reg_w & (Rd == 4'hF)))));
  assign illegal  = rst_n & w_illegal;

endmodule

// File: doc/arm_mc_control_unit.md
# arm_mc_control_unit

Parametrised multicycle control unit for the ARM datapath, successor to the single-cycle controller. It sequences each instruction through a Moore FSM (fetch, decode, execute, memory, writeback), holds the NZCV flag register, and gates all architectural writes with the condition check. The condition check evaluates the registered flags, not the live ALU flags. It sits between the instruction register and the shared-memory multicycle datapath (single memory, PC/IR/A/B/ALUOut registers).

## Interface
- ALUCTRL_W, 2 — ALUControl width. 2 gives ADD/SUB/AND/ORR. 3 adds EOR (cmd 0001 → 3'b100).
- FLAGS_RESET, 4'b0000 — NZCV value loaded on reset.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20] (I, cmd[3:0], S)
- Rd  in  4  Instr[15:12]
- Cond  in  4  Instr[31:28]
- ALUFlags  in  4  live NZCV from ALU
- PCWrite, IRWrite, MemWrite, RegWrite  out  1  write enables
- AdrSrc, ALUSrcA  out  1  mux selects
- ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2  mux selects
- ALUControl  out  ALUCTRL_W  ALU operation
- Flags  out  4  registered NZCV
- illegal  out  1  one-cycle pulse in DECODE for Op=11
- state  out  4  current FSM state (debug)

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE:
    - Op=01 → MEMADR.
    - Op=00, I=0 → EXECUTER.
    - Op=00, I=1 → EXECUTEI.
    - Op=10 → BRANCH.
    - Op=11 → FETCH, with illegal=1.
  - MEMADR: L=Funct[0]=1 → MEMREAD, else MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECUTER/EXECUTEI: cmd=1010 (CMP) → FETCH, else ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH → FETCH.
- Per-state outputs (unlisted selects = 0, enables = 0, ALUControl = ADD):
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW.
  - MEMWRITE: AdrSrc=1, MemW.
  - EXECUTER: ALUSrcB=00, ALU decode.
  - EXECUTEI: ALUSrcB=01, ALU decode.
  - ALUWB: RegW.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch.
- ALU decode by cmd:
  - ADD 0100 → 00; SUB 0010 → 01; AND 0000 → 10; ORR 1100 → 11; CMP 1010 → 01.
  - EOR 0001 → 100 only when ALUCTRL_W=3.
  - Any other cmd → ADD.
- ImmSrc = Op; RegSrc = {Op==01, Op==10}; combinational from instruction fields in every state.
- CondEx comes from Cond against the registered Flags:
  - EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE evaluate per ARM rules.
  - AL = 1; 1111 = 0.
- Write gating:
  - RegWrite = RegW & CondEx.
  - MemWrite = MemW & CondEx.
  - PCWrite = FETCH | (CondEx & (Branch | (RegW & Rd==15))).
- Flag update:
  - Applies at the end of EXECUTER/EXECUTEI when S=1 and CondEx.
  - N,Z always load.
  - C,V load only for ADD, SUB, CMP.
- Failed condition: the FSM still walks the full path; only the writes are suppressed.

## Timing
- Cycles per instruction:
  - LDR 5; STR 4; data-processing 4; CMP 3; B 3; illegal 2.
- Outputs are combinational from registered state and instruction fields. Flags are visible the cycle after the execute state.
- rst_n low:
  - state=FETCH, Flags=FLAGS_RESET.
  - PCWrite, IRWrite, MemWrite, RegWrite, illegal are forced to 0 while reset is asserted.
  - The first fetch occurs on the first rising edge after deassertion.
- Reset mid-instruction aborts immediately. No pending flag or register write completes.
- Simultaneous cases:
  - A flag update and a CondEx evaluation in the same execute cycle: CondEx uses the old flags.
  - A data-processing write to R15 asserts RegWrite and PCWrite together in ALUWB.

## Structure
- Package arm_ctrl_pkg holds:
  - state enum (4-bit);
  - cmd encodings and ALUControl codes;
  - Cond encodings;
  - ResultSrc/ALUSrcB select constants.
- Sub-module arm_mc_main_fsm holds the state register, next-state logic and per-state raw controls (RegW, MemW, Branch, IRWrite, NextPC, selects).
- Top level holds the ALU decoder, Flags register, condition evaluation and write gating.

## Test plan
- Reset asserted mid-MEMWRITE: MemWrite drops to 0 asynchronously; state=FETCH; Flags=FLAGS_RESET; after release, IRWrite=1 on the first cycle.
- LDR (Op=01, Funct=011001, Cond=1110): state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in MEMWB.
- SUBS followed by BEQ with equal operands (ALUFlags=0100): Flags=0100 after EXECUTE; BRANCH asserts PCWrite. Repeat with ALUFlags=0000: no PCWrite in BRANCH.
- CMP (cmd 1010, S=1): 3 cycles, returns to FETCH from EXECUTER, RegWrite never 1, Flags updated.
- ADDNE with Z=1, Rd=15: ALUWB has RegWrite=0 and PCWrite=0; Flags unchanged.
- Op=11: illegal pulses for one cycle in DECODE, next state FETCH, no write enables. With ALUCTRL_W=3, cmd 0001 gives ALUControl=100.
